// File: rtl/booth_op_sequencer_pkg.sv
// Shared definitions for the Booth multiplier front-end: FSM encoding and default sizing.
package booth_op_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam int DEFAULT_N = 8;

    // Worst-case core latency is about 4 cycles per operand bit plus slack.
    function automatic int default_timeout(input int n);
        return 4 * n + 8;
    endfunction

endpackage

// File: rtl/booth_op_sequencer_if.sv
// Operand/result handshakes plus the control/data lines toward the Booth core.
// A transfer happens on a rising edge where valid and ready are both high; the
// sender holds its payload stable while valid is high and ready is low.
interface booth_op_sequencer_if
    import booth_op_sequencer_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_prod;
    logic             out_err;
    logic [N-1:0]     mul_m;
    logic [N-1:0]     mul_q;
    logic             mul_start;
    logic             mul_rst;
    logic             mul_done;
    logic [2*N-1:0]   mul_prod;

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_done, mul_prod,
        input  in_ready, out_valid, out_prod, out_err, mul_m, mul_q, mul_start, mul_rst
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_done, mul_prod,
        output in_ready, out_valid, out_prod, out_err, mul_m, mul_q, mul_start, mul_rst
    );

endinterface

// File: rtl/booth_op_sequencer_watchdog.sv
// Saturating cycle counter that flags the last allowed cycle of a core wait.
module booth_op_sequencer_watchdog #(
    parameter int  LIMIT = 40,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         expired
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/booth_op_sequencer.sv
// Front-end for the Booth multiplier core: takes operand pairs, drives one core
// operation at a time, re-arms the core afterwards and returns product or abort.
module booth_op_sequencer
    import booth_op_sequencer_pkg::*;
#(
    parameter int N           = DEFAULT_N,
    parameter int TIMEOUT     = default_timeout(N),
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    booth_op_sequencer_if.slave          bus,
    output logic                         busy,
    output state_t                       dbg_state,
    output logic [$clog2(TIMEOUT+1)-1:0] dbg_count
);

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [2*N-1:0]   prod_reg;
    logic             err_reg;
    logic             wd_expired;
    logic             bypass_hit;

    assign bypass_hit = BYPASS_ZERO && ((bus.in_a == '0) || (bus.in_b == '0));

    booth_op_sequencer_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .count   (dbg_count),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.in_valid) state_nxt = bypass_hit ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            // A done on the timeout cycle still wins, since both paths go to CLEAR.
            ST_WAIT:  if (bus.mul_done || wd_expired) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_RESP;
            ST_RESP:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            prod_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_a <= bus.in_a;
                        op_b <= bus.in_b;
                        if (bypass_hit) begin
                            prod_reg <= '0;
                            err_reg  <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.mul_done) begin
                        prod_reg <= bus.mul_prod;
                        err_reg  <= 1'b0;
                    end else if (wd_expired) begin
                        prod_reg <= '0;
                        err_reg  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The core latches done until reset, so it is re-armed after every operation.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.mul_start = (state == ST_ISSUE);
        bus.mul_rst   = rst | (state == ST_CLEAR);
        bus.out_valid = (state == ST_RESP);
        busy          = (state != ST_IDLE);
    end

    assign bus.mul_m    = op_a;
    assign bus.mul_q    = op_b;
    assign bus.out_prod = prod_reg;
    assign bus.out_err  = err_reg;
    assign dbg_state    = state;

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Directed bench for booth_op_sequencer with a behavioural Booth core model.
module tb_booth_op_sequencer;
  import booth_op_sequencer_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  state_t dbg_state;
  logic [5:0] dbg_count;

  booth_op_sequencer_if #(.N(8)) bus();

  booth_op_sequencer #(
    .N           (8),
    .TIMEOUT     (40),
    .BYPASS_ZERO (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (act=running exp=finished)");
    $fatal(1, "global timeout");
  end

  // behavioural core: done rises 19 cycles after the start cycle, held until mul_rst
  logic        core_done;
  logic [15:0] core_prod;
  int          core_cnt;
  logic        core_hang;
  logic        stale_done;

  always @(posedge clk) begin
    if (bus.mul_rst) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_prod <= '0;
    end else if (bus.mul_start && !core_hang) begin
      core_cnt  <= 18;
      core_prod <= $signed({{8{bus.mul_m[7]}}, bus.mul_m}) * $signed({{8{bus.mul_q[7]}}, bus.mul_q});
    end else if (core_cnt == 1) begin
      core_done <= 1'b1;
      core_cnt  <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign bus.mul_done = core_done | stale_done;
  assign bus.mul_prod = core_prod;

  // scoreboard counters
  int n_checks;
  int n_pass;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic        err;
    int          lat;
    int          starts;
    int          rsts;
    logic        hang;
  } vec_t;

  vec_t vecs[8];

  // driver: one full operation, optional RESP back-pressure
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_prod, input logic exp_err, input int exp_lat,
                        input int exp_starts, input int exp_rsts, input int hold);
    int lat;
    int starts;
    int rsts;
    int wait_n;
    logic hold_ok;
    logic stable_ok;
    logic got;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    lat = 0; starts = 0; rsts = 0; hold_ok = 1'b1; got = 1'b0;
    while (lat < 200 && !got) begin
      @(negedge clk);
      lat++;
      bus.in_valid = 1'b0;
      if (bus.mul_start) starts++;
      if (bus.mul_rst) rsts++;
      if (bus.mul_m !== a || bus.mul_q !== b) hold_ok = 1'b0;
      if (bus.out_valid) got = 1'b1;
    end
    check({name, "_done"}, 32'(got), 32'd1);
    exp_q.push_back(32'(exp_prod));
    check({name, "_prod"}, 32'(bus.out_prod), exp_q.pop_front());
    check({name, "_err"}, 32'(bus.out_err), 32'(exp_err));
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_starts"}, 32'(starts), 32'(exp_starts));
    check({name, "_mul_rsts"}, 32'(rsts), 32'(exp_rsts));
    check({name, "_operand_hold"}, 32'(hold_ok), 32'd1);
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h11;
        bus.in_b     = 8'h22;
        @(negedge clk);
        if (!(bus.out_valid === 1'b1 && bus.out_prod === exp_prod && bus.out_err === exp_err &&
              bus.in_ready === 1'b0 && dbg_state === ST_RESP && bus.mul_m === a && bus.mul_q === b))
          stable_ok = 1'b0;
      end
      check({name, "_resp_stable"}, 32'(stable_ok), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, "_back_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    check({name, "_out_valid_low"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int wait_n;
    logic stale_ok;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    core_hang  = 1'b0;
    stale_done = 1'b0;

    vecs[0] = '{a: 8'h07, b: 8'h06, prod: 16'h002A, err: 1'b0, lat: 22, starts: 1, rsts: 1, hang: 1'b0};
    vecs[1] = '{a: 8'hFD, b: 8'h05, prod: 16'hFFF1, err: 1'b0, lat: 22, starts: 1, rsts: 1, hang: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h80, prod: 16'h4000, err: 1'b0, lat: 22, starts: 1, rsts: 1, hang: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'h55, prod: 16'h0000, err: 1'b0, lat: 1,  starts: 0, rsts: 0, hang: 1'b0};
    vecs[4] = '{a: 8'h12, b: 8'h00, prod: 16'h0000, err: 1'b0, lat: 1,  starts: 0, rsts: 0, hang: 1'b0};
    vecs[5] = '{a: 8'h07, b: 8'h06, prod: 16'h0000, err: 1'b1, lat: 43, starts: 1, rsts: 1, hang: 1'b1};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, prod: 16'h0001, err: 1'b0, lat: 22, starts: 1, rsts: 1, hang: 1'b0};
    vecs[7] = '{a: 8'h7F, b: 8'h81, prod: 16'hC0FF, err: 1'b0, lat: 22, starts: 1, rsts: 1, hang: 1'b0};

    // reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_prod", 32'(bus.out_prod), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_mul_start", 32'(bus.mul_start), 32'd0);
    check("rst_mul_rst", 32'(bus.mul_rst), 32'd1);
    check("rst_mul_m", 32'(bus.mul_m), 32'd0);
    check("rst_mul_q", 32'(bus.mul_q), 32'd0);
    check("rst_wd_count", 32'(dbg_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_mul_rst", 32'(bus.mul_rst), 32'd0);

    // table-driven operations
    for (int i = 0; i < 8; i++) begin
      core_hang = vecs[i].hang;
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].err,
             vecs[i].lat, vecs[i].starts, vecs[i].rsts, 0);
      core_hang = 1'b0;
    end

    // back-pressure in RESP, then the queued pair is accepted after the handshake
    run_op("hold", 8'h07, 8'h06, 16'h002A, 1'b0, 22, 1, 1, 5);
    check("hold_in_ready_after", 32'(bus.in_ready), 32'd1);
    run_op("after_hold", 8'h11, 8'h22, 16'h0242, 1'b0, 22, 1, 1, 0);

    // reset while waiting on the core
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h03;
    bus.in_b     = 8'h04;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_n = 0;
    while (dbg_state != ST_WAIT && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    check("mid_reached_wait", 32'(dbg_state), 32'(ST_WAIT));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_mul_rst", 32'(bus.mul_rst), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_mul_m", 32'(bus.mul_m), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release_ready", 32'(bus.in_ready), 32'd1);

    // stale done while idle must be ignored
    stale_done = 1'b1;
    stale_ok   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dbg_state !== ST_IDLE || bus.out_valid !== 1'b0) stale_ok = 1'b0;
    end
    stale_done = 1'b0;
    check("stale_done_ignored", 32'(stale_ok), 32'd1);
    @(negedge clk);

    run_op("b2b_0", 8'h03, 8'h04, 16'h000C, 1'b0, 22, 1, 1, 0);
    run_op("b2b_1", 8'hF6, 8'h0C, 16'hFF88, 1'b0, 22, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
